// File: rtl/vector_join_unit.sv
// vector_join_unit: collects N-lane beats into a V-element vector using strided
// or packed placement, with valid/ready handshakes on both sides and early
// termination that leaves the unwritten elements at zero.
module vector_join_unit #(
  parameter int unsigned L = 8,
  parameter int unsigned V = 20,
  parameter int unsigned N = 4,
  localparam int unsigned S  = V / N,
  localparam int unsigned CW = $clog2(S + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    mode_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    in_last_i,
  input  logic [N-1:0][L-1:0]     vector_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [V-1:0][L-1:0]     vector_o,
  output logic [CW-1:0]           count_o
);

  localparam int unsigned IW = (V > 1) ? $clog2(V) : 1;

  typedef enum logic {FILL, FULL} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         b_q, b_d;
  logic                  m_q, m_d;
  logic [V-1:0][L-1:0]   buf_q, buf_d;
  logic [V-1:0][L-1:0]   vec_q, vec_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  m_eff;
  logic [IW-1:0]         idx;
  logic [V-1:0][L-1:0]   merged;

  // Ready is a pure state decode, held low while reset is asserted.
  assign in_ready_o  = (state_q == FILL) && !RST;
  assign out_valid_o = (state_q == FULL);
  assign vector_o    = vec_q;
  assign count_o     = cnt_q;

  // Register all state; reset discards any partial or pending vector.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FILL;
      b_q     <= '0;
      m_q     <= 1'b0;
      buf_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      m_q     <= m_d;
      buf_q   <= buf_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

  // Merge the current beat into the buffer and decide the next state.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    m_d     = m_q;
    buf_d   = buf_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    idx     = '0;
    merged  = buf_q;

    // The mode for the whole vector is taken from the beat at b = 0.
    m_eff = (b_q == '0) ? mode_i : m_q;

    for (int unsigned j = 0; j < N; j++) begin
      if (m_eff) idx = IW'(32'(b_q) * N + j);
      else       idx = IW'(32'(b_q) + j * S);
      merged[idx] = vector_i[j];
    end

    case (state_q)
      FILL: begin
        if (in_valid_i) begin
          m_d = m_eff;
          if (in_last_i || (b_q == CW'(S - 1))) begin
            vec_d   = merged;
            cnt_d   = b_q + CW'(1);
            buf_d   = '0;
            b_d     = '0;
            state_d = FULL;
          end else begin
            buf_d = merged;
            b_d   = b_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (out_ready_i) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule
